// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller takes the master modport; the datapath (or bench) takes the slave modport.
interface multicycle_controller_if;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 3;
  localparam int unsigned STATE_W  = 4;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                MemReq;
  logic                MemWrite;
  logic                IRWrite;
  logic                PCWrite;
  logic                RegWrite;
  logic                AdrSrc;
  logic [SEL_W-1:0]    ResultsSrc;
  logic [SEL_W-1:0]    ALUSrcA;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [SEL_W-1:0]    ALUop;
  logic [IMM_W-1:0]    ImmSrc;
  logic                Fault;
  logic [STATE_W-1:0]  State;

  modport master (
    input  opcode, zero, mem_ready,
    output MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
           ResultsSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, Fault, State
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
           ResultsSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, Fault, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with a memory-stall timeout that parks in a sticky FAULT state.
// Control outputs are a combinational decode of the current state (plus mem_ready/zero gating).
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    FAULT    = 4'd15
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             in_wait;
  logic             stall_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Stall that would be the MEM_TIMEOUT-th in a row; a same-cycle mem_ready takes priority.
  always_comb begin
    in_wait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    stall_limit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST) && !bus.mem_ready;
  end

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state) begin
      wait_cnt_next = '0;
    end else if (in_wait && !bus.mem_ready && (wait_cnt != CNT_MAX)) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next     = state;
    bus.MemReq     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultsSrc = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUop      = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.Fault      = 1'b0;

    unique case (state)
      FETCH: begin
        bus.MemReq     = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ResultsSrc = 2'b10;
        bus.IRWrite    = bus.mem_ready;
        bus.PCWrite    = bus.mem_ready;
        if (bus.mem_ready)  state_next = DECODE;
        else if (stall_limit) state_next = FAULT;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_JAL:            state_next = JAL;
          OP_BEQ:            state_next = BEQ;
          default:           state_next = FAULT;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        if (bus.opcode == OP_STORE) begin
          bus.ImmSrc = 3'b001;
          state_next = MEMWRITE;
        end else begin
          state_next = MEMREAD;
        end
      end
      MEMREAD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready)    state_next = MEMWB;
        else if (stall_limit) state_next = FAULT;
      end
      MEMWB: begin
        bus.ResultsSrc = 2'b01;
        bus.RegWrite   = 1'b1;
        state_next     = FETCH;
      end
      MEMWRITE: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
        if (bus.mem_ready)    state_next = FETCH;
        else if (stall_limit) state_next = FAULT;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUop   = 2'b10;
        state_next  = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUop   = 2'b10;
        state_next  = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_next   = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_next  = ALUWB;
      end
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUop   = 2'b01;
        bus.PCWrite = bus.zero;
        state_next  = FETCH;
      end
      FAULT: begin
        bus.Fault = 1'b1;
      end
      // Unused codes 11-14 fall into FAULT on the next edge.
      default: state_next = FAULT;
    endcase
  end

  assign bus.State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a vector table, hand-written stall/timeout/reset sequences,
// and a randomized run against an instruction-route reference model.
module tb_multicycle_controller;
  localparam int unsigned T = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef struct packed {
    logic       memreq, memwrite, irwrite, pcwrite, regwrite, adrsrc;
    logic [1:0] res, asa, asb, aluop;
    logic [2:0] imm;
    logic       fault;
    logic [3:0] st;
  } ctrl_t;

  typedef struct {
    logic [6:0] op;
    logic       mr, z;
    logic [3:0] st;
    logic       memreq, regwrite, pcwrite, irwrite;
    logic [1:0] aluop;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_controller_if bus ();
  multicycle_controller #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic mr, input logic z);
    bus.opcode = op; bus.mem_ready = mr; bus.zero = z;
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic ctrl_t observed();
    ctrl_t c;
    c.memreq = bus.MemReq;   c.memwrite = bus.MemWrite; c.irwrite = bus.IRWrite;
    c.pcwrite = bus.PCWrite; c.regwrite = bus.RegWrite; c.adrsrc = bus.AdrSrc;
    c.res = bus.ResultsSrc;  c.asa = bus.ALUSrcA;       c.asb = bus.ALUSrcB;
    c.aluop = bus.ALUop;     c.imm = bus.ImmSrc;        c.fault = bus.Fault;
    c.st = bus.State;
    return c;
  endfunction

  // Required control word for each state code, straight from the state/output table.
  function automatic ctrl_t expected(input int st, input logic [6:0] op, input logic mr, input logic z);
    ctrl_t c = '0;
    c.st = 4'(st);
    case (st)
      0:  begin c.memreq = 1; c.asb = 2'b10; c.res = 2'b10; c.irwrite = mr; c.pcwrite = mr; end
      1:  begin c.asa = 2'b01; c.asb = 2'b01; c.imm = (op == OP_JAL) ? 3'b011 : 3'b010; end
      2:  begin c.asa = 2'b10; c.asb = 2'b01; c.imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
      3:  begin c.memreq = 1; c.adrsrc = 1; end
      4:  begin c.res = 2'b01; c.regwrite = 1; end
      5:  begin c.memreq = 1; c.memwrite = 1; c.adrsrc = 1; end
      6:  begin c.asa = 2'b10; c.aluop = 2'b10; end
      7:  begin c.regwrite = 1; end
      8:  begin c.asa = 2'b10; c.asb = 2'b01; c.aluop = 2'b10; end
      9:  begin c.asa = 2'b01; c.asb = 2'b10; c.pcwrite = 1; end
      10: begin c.asa = 2'b10; c.aluop = 2'b01; c.pcwrite = z; end
      15: begin c.fault = 1; end
      default: ;
    endcase
    return c;
  endfunction

  vec_t vt[21];

  initial begin
    logic [6:0] op;
    logic       mr, z;
    int         cur, stall, fault_cycles;
    int         route[$];

    vt[0]  = '{OP_RTYPE, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[1]  = '{OP_RTYPE, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[2]  = '{OP_RTYPE, 1'b1, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[3]  = '{OP_RTYPE, 1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[4]  = '{OP_BEQ,   1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[5]  = '{OP_BEQ,   1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[6]  = '{OP_BEQ,   1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
    vt[7]  = '{OP_BEQ,   1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[8]  = '{OP_BEQ,   1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[9]  = '{OP_BEQ,   1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[10] = '{OP_JAL,   1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[11] = '{OP_JAL,   1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[12] = '{OP_JAL,   1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vt[13] = '{OP_JAL,   1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[14] = '{OP_ITYPE, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[15] = '{OP_ITYPE, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[16] = '{OP_ITYPE, 1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[17] = '{OP_ITYPE, 1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vt[18] = '{OP_ITYPE, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[19] = '{OP_ITYPE, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[20] = '{OP_ITYPE, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    // Reset state, sampled while rst is still high.
    drive(OP_RTYPE, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_word", 32'(observed()), 32'(expected(0, OP_RTYPE, 1'b1, 1'b0)));
    apply_reset();

    // Table-driven sequences: add, beq taken / not taken, jal, addi, fetch stall.
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].op, vt[i].mr, vt[i].z);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          32'({bus.State, bus.MemReq, bus.RegWrite, bus.PCWrite, bus.IRWrite, bus.ALUop}),
          32'({vt[i].st, vt[i].memreq, vt[i].regwrite, vt[i].pcwrite, vt[i].irwrite, vt[i].aluop}));
      advance();
    end

    // Load with three stalls in MEMREAD: one short of the timeout, ready wins on the 4th cycle.
    apply_reset();
    drive(OP_LOAD, 1'b1, 1'b0);
    @(negedge clk); chk("lw_fetch", 32'(bus.State), 32'd0); advance();
    @(negedge clk); chk("lw_decode_imm", 32'({bus.State, bus.ImmSrc}), 32'({4'd1, 3'b010})); advance();
    @(negedge clk); chk("lw_memadr_imm", 32'({bus.State, bus.ImmSrc}), 32'({4'd2, 3'b000})); advance();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("lw_memread%0d", i), 32'({bus.State, bus.MemReq, bus.AdrSrc}), 32'({4'd3, 1'b1, 1'b1}));
      advance();
    end
    @(negedge clk);
    chk("lw_memwb", 32'({bus.State, bus.ResultsSrc, bus.RegWrite}), 32'({4'd4, 2'b01, 1'b1}));
    advance();
    @(negedge clk); chk("lw_back_fetch", 32'(bus.State), 32'd0);
    advance();

    // Store with memory never ready: four MEMWRITE cycles, then sticky FAULT.
    apply_reset();
    drive(OP_STORE, 1'b1, 1'b0);
    advance();
    @(negedge clk); chk("sw_decode", 32'(bus.State), 32'd1); advance();
    @(negedge clk); chk("sw_memadr_imm", 32'({bus.State, bus.ImmSrc}), 32'({4'd2, 3'b001})); advance();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sw_stall%0d", i), 32'({bus.State, bus.MemWrite}), 32'({4'd5, 1'b1}));
      advance();
    end
    @(negedge clk);
    chk("sw_timeout", 32'(observed()), 32'(expected(15, OP_STORE, 1'b0, 1'b0)));

    // Fetch that never completes times out the same way.
    apply_reset();
    drive(OP_RTYPE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("fetch_stall%0d", i), 32'(bus.State), 32'd0); advance();
    end
    @(negedge clk); chk("fetch_timeout", 32'({bus.State, bus.Fault}), 32'({4'd15, 1'b1}));

    // Illegal opcode: FAULT held for 20 cycles, cleared only by rst.
    apply_reset();
    drive(OP_BAD, 1'b1, 1'b0);
    advance();
    @(negedge clk); chk("bad_decode", 32'(bus.State), 32'd1); advance();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bad_fault%0d", i), 32'({bus.State, bus.Fault, bus.MemReq}), 32'({4'd15, 1'b1, 1'b0}));
      advance();
    end
    #1 rst = 1'b1;
    #1 chk("bad_rst_async", 32'({bus.State, bus.Fault}), 32'({4'd0, 1'b0}));
    apply_reset();

    // rst between edges in the middle of a store drops MemWrite at once.
    drive(OP_STORE, 1'b1, 1'b0);
    advance();
    bus.mem_ready = 1'b0;
    advance(); advance();
    @(negedge clk); chk("midstore_pre", 32'({bus.State, bus.MemWrite}), 32'({4'd5, 1'b1}));
    #2 rst = 1'b1;
    #1 chk("midstore_rst", 32'({bus.State, bus.MemWrite, bus.MemReq}), 32'({4'd0, 1'b0, 1'b1}));
    apply_reset();

    // Randomized run: the model walks each instruction's route of states.
    cur = 0; stall = 0; fault_cycles = 0; op = OP_RTYPE;
    for (int n = 0; n < 3000; n++) begin
      if (cur == 0) begin
        case ($urandom_range(0, 15))
          0, 1, 2:  op = OP_RTYPE;
          3, 4:     op = OP_ITYPE;
          5, 6, 7:  op = OP_LOAD;
          8, 9, 10: op = OP_STORE;
          11, 12:   op = OP_BEQ;
          13, 14:   op = OP_JAL;
          default:  op = 7'($urandom);
        endcase
      end
      mr = ($urandom_range(0, 3) != 0);
      z  = 1'($urandom_range(0, 1));
      drive(op, mr, z);
      @(negedge clk);
      chk("rand", 32'(observed()), 32'(expected(cur, op, mr, z)));

      if (cur == 15) begin
        fault_cycles++;
      end else if (cur == 0 || cur == 3 || cur == 5) begin
        if (mr) begin
          stall = 0;
          if (cur == 0) cur = 1;
          else cur = (route.size() > 0) ? route.pop_front() : 0;
        end else begin
          stall++;
          if (stall == T) begin cur = 15; stall = 0; end
        end
      end else if (cur == 1) begin
        route.delete();
        case (op)
          OP_LOAD:  route = '{2, 3, 4};
          OP_STORE: route = '{2, 5};
          OP_RTYPE: route = '{6, 7};
          OP_ITYPE: route = '{8, 7};
          OP_JAL:   route = '{9, 7};
          OP_BEQ:   route = '{10};
          default:  route = '{15};
        endcase
        cur = route.pop_front();
      end else begin
        cur = (route.size() > 0) ? route.pop_front() : 0;
      end

      if (fault_cycles >= 3) begin
        apply_reset();
        cur = 0; stall = 0; fault_cycles = 0;
        route.delete();
      end else begin
        advance();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
